// File: rtl/arm_pkg.sv
// arm_pkg: shared register-file and scoreboard sizing constants
package arm_pkg;
  localparam int REG_ADDR_W = 4;
  localparam int NUM_REGS = 16;
  localparam int SB_CNT_W = 2;
endpackage

// File: rtl/reg_scoreboard_if.sv
// reg_scoreboard_if: issue/writeback/source-operand bundle between pipeline and scoreboard
interface reg_scoreboard_if import arm_pkg::*; #(parameter int N = arm_pkg::NUM_REGS);
  logic issue_valid;
  logic issue_wb_en;
  logic [REG_ADDR_W-1:0] issue_dest;
  logic wb_valid;
  logic [REG_ADDR_W-1:0] wb_dest;
  logic [REG_ADDR_W-1:0] src1;
  logic [REG_ADDR_W-1:0] src2;
  logic has_two_src;
  logic Ignore_Hazard;
  logic freeze;
  logic hazard_detected;
  logic [N-1:0] busy_vec;
  logic sb_err;
  modport master (
    output issue_valid, issue_wb_en, issue_dest, wb_valid, wb_dest,
           src1, src2, has_two_src, Ignore_Hazard, freeze,
    input  hazard_detected, busy_vec, sb_err
  );
  modport slave (
    input  issue_valid, issue_wb_en, issue_dest, wb_valid, wb_dest,
           src1, src2, has_two_src, Ignore_Hazard, freeze,
    output hazard_detected, busy_vec, sb_err
  );
endinterface

// File: rtl/sb_entry.sv
// sb_entry: saturating pending-write counter for one register with overflow/underflow flags
module sb_entry #(parameter int CNT_W = 2) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic dec,
  output logic [CNT_W-1:0] count,
  output logic ovf,
  output logic udf
);
  logic [CNT_W-1:0] count_nx;
  assign ovf = inc & !dec & (count == {CNT_W{1'b1}});
  assign udf = dec & !inc & (count == '0);
  always_comb begin
    count_nx = count;
    if (inc & !dec & !ovf) count_nx = count + CNT_W'(1);
    else if (dec & !inc & !udf) count_nx = count - CNT_W'(1);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else count <= count_nx;
endmodule

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register in-flight write tracking and ID-stage RAW hazard detection
module reg_scoreboard import arm_pkg::*; #(
  parameter int NUM_REGS = arm_pkg::NUM_REGS,
  parameter int CNT_W = arm_pkg::SB_CNT_W
) (
  input logic clk,
  input logic rst_n,
  reg_scoreboard_if.slave sb
);
  logic [NUM_REGS-1:0] iss_hit, wb_hit, ovf, udf, pend;
  logic [CNT_W-1:0] cnt [NUM_REGS];
  logic err;
  genvar r;
  for (r = 0; r < NUM_REGS; r++) begin : g_entry
    assign iss_hit[r] = sb.issue_valid & sb.issue_wb_en & (sb.issue_dest == REG_ADDR_W'(r)) & !sb.freeze;
    assign wb_hit[r] = sb.wb_valid & (sb.wb_dest == REG_ADDR_W'(r)) & !sb.freeze;
    sb_entry #(.CNT_W(CNT_W)) u_entry (
      .clk(clk), .rst_n(rst_n), .inc(iss_hit[r]), .dec(wb_hit[r]),
      .count(cnt[r]), .ovf(ovf[r]), .udf(udf[r])
    );
    // a last outstanding write committing this cycle is forwarded by the register file
    assign pend[r] = (cnt[r] != '0) & !((cnt[r] == CNT_W'(1)) & wb_hit[r]);
    assign sb.busy_vec[r] = cnt[r] != '0;
  end
  assign sb.hazard_detected = !sb.Ignore_Hazard & (pend[sb.src1] | (sb.has_two_src & pend[sb.src2]));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) err <= 1'b0;
    else if (|(ovf | udf)) err <= 1'b1;
  assign sb.sb_err = err;
endmodule
